// File: rtl/out_reg_shift_mc_if.sv
// Valid/ready bus carrying CH signed lanes of DW bits each.
// master drives vld/dat, slave drives rdy.
interface out_reg_shift_mc_if #(
  parameter int CH = 4,
  parameter int DW = 16
);
  logic            vld;
  logic            rdy;
  logic [CH*DW-1:0] dat;

  modport master (output vld, output dat, input rdy);
  modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/out_reg_shift_mc.sv
// Per-lane delay/alignment of PE-array partial sums by D = filter_size - columns accepted samples,
// with optional saturating accumulate; output registered 1 cycle after the producing accept or drain step.
// Backpressure: input stalls whenever the output register is full and not being consumed, and during drain.
module out_reg_shift_mc #(
  parameter int I_WIDTH       = 8,
  parameter int F_WIDTH       = 8,
  parameter int N             = 3,
  parameter int CH            = 4,
  parameter int NUM_COL_WIDTH = $clog2(N + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     cfg_ld_i,
  input  logic [NUM_COL_WIDTH-1:0] filter_size_i,
  input  logic [NUM_COL_WIDTH-1:0] number_of_columns_i,
  input  logic                     acc_mode_i,
  input  logic                     flush_i,
  out_reg_shift_mc_if.slave        in_if,
  out_reg_shift_mc_if.master       out_if,
  output logic [NUM_COL_WIDTH-1:0] number_of_columns_o,
  output logic                     busy_o,
  output logic                     cfg_err_o,
  output logic                     sat_o
);

  localparam int DW = I_WIDTH + F_WIDTH;
  localparam int W  = CH * DW;
  localparam logic [NUM_COL_WIDTH-1:0] CNT_ONE = NUM_COL_WIDTH'(1);
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [NUM_COL_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_COL_WIDTH-1:0] d_q, ncol_q;
  logic                     acc_q, cfg_err_q;
  // N entries so that cols = 0 (D = filter_size = N) still has a valid tap
  logic [DW-1:0]            line_q [CH][N];
  logic                     out_vld_q, sat_q;
  logic [W-1:0]             out_dat_q;

  logic         out_free, in_rdy_c, accept, drain_step, produce, shift_en, line_zero;
  logic         cfg_ok;
  logic [W-1:0] res_dat;
  logic         res_sat;

  assign out_free = !out_vld_q || out_if.rdy;
  assign cfg_ok   = (filter_size_i != '0) && (int'(filter_size_i) <= N) &&
                    (number_of_columns_i <= filter_size_i);

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (d_q > CNT_ONE) begin
            state_d = FILL;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = STREAM;
          end
        end
      end
      FILL: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == d_q) begin
            state_d = STREAM;
            cnt_d   = '0;
          end
        end
      end
      STREAM: begin
        if (flush_i) begin
          state_d = (d_q == '0) ? IDLE : DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (drain_step) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == d_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM-derived controls
  always_comb begin
    in_rdy_c   = (state_q != DRAIN) && out_free;
    accept     = in_if.vld && in_rdy_c;
    drain_step = (state_q == DRAIN) && out_free;
    produce    = drain_step ||
                 (accept && ((state_q == STREAM) || ((state_q == IDLE) && (d_q == '0))));
    shift_en   = accept || drain_step;
    line_zero  = (state_q == FILL) && flush_i;
  end

  assign in_if.rdy = in_rdy_c;

  // Drain feeds zeros, so accumulate mode emits the bare tap while draining
  always_comb begin
    logic [DW-1:0] a, t;
    logic [DW:0]   s;
    res_dat = '0;
    res_sat = 1'b0;
    for (int k = 0; k < CH; k++) begin
      a = (state_q == DRAIN) ? '0 : in_if.dat[k*DW +: DW];
      t = '0;
      for (int i = 0; i < N; i++) begin
        if (d_q == NUM_COL_WIDTH'(i + 1)) t = line_q[k][i];
      end
      s = {a[DW-1], a} + {t[DW-1], t};
      if (d_q == '0) begin
        res_dat[k*DW +: DW] = a;
      end else if (!acc_q) begin
        res_dat[k*DW +: DW] = t;
      end else if (s[DW] != s[DW-1]) begin
        res_dat[k*DW +: DW] = s[DW] ? SAT_MIN : SAT_MAX;
        res_sat             = 1'b1;
      end else begin
        res_dat[k*DW +: DW] = s[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < CH; k++)
        for (int i = 0; i < N; i++) line_q[k][i] <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sat_q     <= 1'b0;
      d_q       <= '0;
      ncol_q    <= '0;
      acc_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (clr_i) begin
      for (int k = 0; k < CH; k++)
        for (int i = 0; i < N; i++) line_q[k][i] <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      if (cfg_ld_i && (state_q == IDLE)) begin
        if (cfg_ok) begin
          d_q       <= filter_size_i - number_of_columns_i;
          ncol_q    <= number_of_columns_i;
          acc_q     <= acc_mode_i;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end

      if (line_zero) begin
        for (int k = 0; k < CH; k++)
          for (int i = 0; i < N; i++) line_q[k][i] <= '0;
      end else if (shift_en) begin
        for (int k = 0; k < CH; k++) begin
          line_q[k][0] <= drain_step ? '0 : in_if.dat[k*DW +: DW];
          for (int i = 1; i < N; i++) line_q[k][i] <= line_q[k][i-1];
        end
      end

      sat_q <= produce && res_sat;
      if (produce) begin
        out_vld_q <= 1'b1;
        out_dat_q <= res_dat;
      end else if (out_if.rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_if.vld          = out_vld_q;
  assign out_if.dat          = out_dat_q;
  assign number_of_columns_o = ncol_q;
  assign busy_o              = (state_q != IDLE) || out_vld_q;
  assign cfg_err_o           = cfg_err_q;
  assign sat_o               = sat_q;

endmodule
